// File: rtl/game_pkg.sv
// Shared constants and state types for the Mario display, collision, sprite and motion blocks.
package game_pkg;

    localparam int SCREEN_W     = 320;
    localparam int SCREEN_H     = 240;
    localparam int WORLD_X_MAX  = 3375;
    localparam int MARIO_HALF_W = 4;
    localparam int MARIO_HALF_H = 16;
    localparam int CAM_CENTER   = 160;
    localparam int OFFSET_MAX   = 3056;

    // Legal sprite-centre limits derived from the world and sprite geometry.
    localparam int X_MIN = MARIO_HALF_W;
    localparam int X_MAX = WORLD_X_MAX - MARIO_HALF_W;
    localparam int Y_MIN = MARIO_HALF_H;

    localparam int COL_N     = 4;
    localparam int COL_HEAD  = 0;
    localparam int COL_FEET  = 1;
    localparam int COL_LEFT  = 2;
    localparam int COL_RIGHT = 3;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } motion_state_t;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_HORIZ  = 3'd1,
        SEQ_VERT   = 3'd2,
        SEQ_CAMERA = 3'd3,
        SEQ_COMMIT = 3'd4
    } seq_state_t;

    function automatic logic [11:0] cam_offset(input logic [12:0] x);
        logic [13:0] w_diff;
        if ({1'b0, x} <= 14'(CAM_CENTER)) begin
            return '0;
        end
        w_diff = {1'b0, x} - 14'(CAM_CENTER);
        if (w_diff > 14'(OFFSET_MAX)) begin
            return 12'(OFFSET_MAX);
        end
        return 12'(w_diff);
    endfunction

endpackage

// File: rtl/mario_motion_ctrl_if.sv
// Frame strobe, buttons and collision pulses in; committed sprite position and camera out.
interface mario_motion_ctrl_if;
    import game_pkg::*;

    logic          new_frame;
    logic          btn_left;
    logic          btn_right;
    logic          btn_jump;
    logic          collide_head_in;
    logic          collide_feet_in;
    logic          collide_left_in;
    logic          collide_right_in;
    logic [12:0]   x_mario_center;
    logic [9:0]    y_mario_center;
    logic [11:0]   offset;
    motion_state_t motion_state_out;
    logic          update_done;

    modport master (
        output new_frame, btn_left, btn_right, btn_jump,
        output collide_head_in, collide_feet_in, collide_left_in, collide_right_in,
        input  x_mario_center, y_mario_center, offset, motion_state_out, update_done
    );

    modport slave (
        input  new_frame, btn_left, btn_right, btn_jump,
        input  collide_head_in, collide_feet_in, collide_left_in, collide_right_in,
        output x_mario_center, y_mario_center, offset, motion_state_out, update_done
    );

endinterface

// File: rtl/collision_latch.sv
// Sticky per-frame collision flags; i_snap copies the flags out and restarts them from this cycle's pulses.
module collision_latch
    import game_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_snap,
    input  logic [COL_N-1:0] i_pulse,
    output logic [COL_N-1:0] o_snap
);

    logic [COL_N-1:0] r_flags;
    logic [COL_N-1:0] r_snap;

    // A pulse coincident with the snapshot belongs to the frame that is just starting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flags <= '0;
            r_snap  <= '0;
        end else if (i_snap) begin
            r_snap  <= r_flags;
            r_flags <= i_pulse;
        end else begin
            r_flags <= r_flags | i_pulse;
        end
    end

    assign o_snap = r_snap;

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame player motion: horizontal walk, jump/fall state machine and camera scroll,
// computed on working copies and published to the outputs in a single commit.
module mario_motion_ctrl
    import game_pkg::*;
#(
    parameter int WALK_SPEED = 2,
    parameter int JUMP_V0    = 8,
    parameter int MAX_FALL   = 6,
    parameter int X_START    = 40,
    parameter int Y_START    = 207,
    parameter int Y_FLOOR    = 223
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    mario_motion_ctrl_if.slave  bus
);

    seq_state_t    r_seq;
    seq_state_t    w_seq_next;
    logic          w_done;
    logic          w_start;

    logic [COL_N-1:0] w_col_pulse;
    logic [COL_N-1:0] w_col;

    logic          r_btn_l;
    logic          r_btn_r;
    logic          r_btn_j;

    logic [12:0]   r_x_w;
    logic [9:0]    r_y_w;
    logic [3:0]    r_vy;
    motion_state_t r_mstate_w;

    logic [12:0]   r_x_out;
    logic [9:0]    r_y_out;
    logic [11:0]   r_off_out;
    motion_state_t r_mstate_out;

    logic [12:0]   w_x_next;
    logic [13:0]   w_x_ext;
    logic [9:0]    w_y_next;
    logic [10:0]   w_y_ext;
    logic [10:0]   w_vy_ext;
    logic [3:0]    w_vy_next;
    motion_state_t w_mstate_next;

    assign w_start     = (r_seq == SEQ_IDLE) && bus.new_frame;
    assign w_col_pulse = {bus.collide_right_in, bus.collide_left_in,
                          bus.collide_feet_in,  bus.collide_head_in};

    collision_latch u_collision_latch (
        .i_clk   (pixel_clk_in),
        .i_rst   (rst_in),
        .i_snap  (w_start),
        .i_pulse (w_col_pulse),
        .o_snap  (w_col)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_seq <= SEQ_IDLE;
        end else begin
            r_seq <= w_seq_next;
        end
    end

    always_comb begin
        w_seq_next = r_seq;
        w_done     = 1'b0;
        case (r_seq)
            SEQ_IDLE:   if (bus.new_frame) w_seq_next = SEQ_HORIZ;
            SEQ_HORIZ:  w_seq_next = SEQ_VERT;
            SEQ_VERT:   w_seq_next = SEQ_CAMERA;
            SEQ_CAMERA: w_seq_next = SEQ_COMMIT;
            SEQ_COMMIT: begin
                w_seq_next = SEQ_IDLE;
                w_done     = 1'b1;
            end
            default:    w_seq_next = SEQ_IDLE;
        endcase
    end

    // Comparisons run one bit wider than the operands so a step past a limit clamps instead of wrapping.
    assign w_x_ext  = {1'b0, r_x_w};
    assign w_y_ext  = {1'b0, r_y_w};
    assign w_vy_ext = {7'b0, r_vy};

    always_comb begin
        w_x_next = r_x_w;
        if (r_btn_r && !r_btn_l && !w_col[COL_RIGHT]) begin
            w_x_next = (w_x_ext + 14'(WALK_SPEED) > 14'(X_MAX)) ? 13'(X_MAX)
                                                                 : 13'(w_x_ext + 14'(WALK_SPEED));
        end else if (r_btn_l && !r_btn_r && !w_col[COL_LEFT]) begin
            w_x_next = (w_x_ext < 14'(X_MIN) + 14'(WALK_SPEED)) ? 13'(X_MIN)
                                                                 : 13'(w_x_ext - 14'(WALK_SPEED));
        end
    end

    always_comb begin
        w_y_next      = r_y_w;
        w_vy_next     = r_vy;
        w_mstate_next = r_mstate_w;
        case (r_mstate_w)
            GROUND: begin
                if (r_btn_j && !w_col[COL_HEAD]) begin
                    w_mstate_next = RISE;
                    w_vy_next     = 4'(JUMP_V0);
                end else if (!w_col[COL_FEET] && w_y_ext < 11'(Y_FLOOR)) begin
                    w_mstate_next = FALL;
                    w_vy_next     = '0;
                end
            end
            RISE: begin
                if (w_col[COL_HEAD]) begin
                    w_mstate_next = FALL;
                    w_vy_next     = '0;
                end else begin
                    w_y_next  = (w_y_ext < w_vy_ext + 11'(Y_MIN)) ? 10'(Y_MIN)
                                                                  : 10'(w_y_ext - w_vy_ext);
                    w_vy_next = (r_vy == 4'd0) ? 4'd0 : r_vy - 4'd1;
                    if (r_vy <= 4'd1) begin
                        w_mstate_next = FALL;
                    end
                end
            end
            FALL: begin
                if (w_col[COL_FEET]) begin
                    w_mstate_next = GROUND;
                end else if (w_y_ext + w_vy_ext >= 11'(Y_FLOOR)) begin
                    w_y_next      = 10'(Y_FLOOR);
                    w_vy_next     = '0;
                    w_mstate_next = GROUND;
                end else begin
                    w_y_next  = 10'(w_y_ext + w_vy_ext);
                    w_vy_next = (r_vy >= 4'(MAX_FALL)) ? 4'(MAX_FALL) : r_vy + 4'd1;
                end
            end
            default: w_mstate_next = GROUND;
        endcase
    end

    // Outputs load on the edge that enters COMMIT, so they become visible together with update_done.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_btn_l      <= 1'b0;
            r_btn_r      <= 1'b0;
            r_btn_j      <= 1'b0;
            r_x_w        <= 13'(X_START);
            r_y_w        <= 10'(Y_START);
            r_vy         <= '0;
            r_mstate_w   <= GROUND;
            r_x_out      <= 13'(X_START);
            r_y_out      <= 10'(Y_START);
            r_off_out    <= '0;
            r_mstate_out <= GROUND;
        end else begin
            if (w_start) begin
                r_btn_l <= bus.btn_left;
                r_btn_r <= bus.btn_right;
                r_btn_j <= bus.btn_jump;
            end
            case (r_seq)
                SEQ_HORIZ: r_x_w <= w_x_next;
                SEQ_VERT: begin
                    r_y_w      <= w_y_next;
                    r_vy       <= w_vy_next;
                    r_mstate_w <= w_mstate_next;
                end
                SEQ_CAMERA: begin
                    r_x_out      <= r_x_w;
                    r_y_out      <= r_y_w;
                    r_off_out    <= cam_offset(r_x_w);
                    r_mstate_out <= r_mstate_w;
                end
                default: ;
            endcase
        end
    end

    assign bus.x_mario_center   = r_x_out;
    assign bus.y_mario_center   = r_y_out;
    assign bus.offset           = r_off_out;
    assign bus.motion_state_out = r_mstate_out;
    assign bus.update_done      = w_done;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Bench for mario_motion_ctrl: hand-derived frame table, random frames against a frame-level model, wall and camera corners.
module tb_mario_motion_ctrl;
    import game_pkg::*;

    localparam int WS = 2;
    localparam int V0 = 8;
    localparam int MF = 6;
    localparam int XS = 40;
    localparam int YS = 207;
    localparam int YF = 223;

    localparam bit [3:0] CH = 4'h1;
    localparam bit [3:0] CF = 4'h2;
    localparam bit [3:0] CL = 4'h4;
    localparam bit [3:0] CR = 4'h8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mario_motion_ctrl_if bus();

    mario_motion_ctrl #(
        .WALK_SPEED (WS),
        .JUMP_V0    (V0),
        .MAX_FALL   (MF),
        .X_START    (XS),
        .Y_START    (YS),
        .Y_FLOOR    (YF)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    typedef struct {
        bit       l, r, j;
        bit [3:0] cb, cs;
        int       ex, ey, eoff, est;
    } vec_t;

    vec_t tbl[$];

    int nvec  = 0;
    int nfail = 0;

    // Frame-level reference: position, speed, vertical state, camera, pending collision flags.
    int       mx, my, mvy, mst, moff;
    bit [3:0] mflags;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coll(input bit [3:0] c);
        bus.collide_head_in  = c[0];
        bus.collide_feet_in  = c[1];
        bus.collide_left_in  = c[2];
        bus.collide_right_in = c[3];
    endtask

    task automatic model_reset();
        mx = XS; my = YS; mvy = 0; mst = 0; moff = 0; mflags = '0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit j, input bit [3:0] s);
        if (r && !l && !s[3])      mx = (mx + WS > 3371) ? 3371 : mx + WS;
        else if (l && !r && !s[2]) mx = (mx - WS < 4) ? 4 : mx - WS;
        case (mst)
            0: begin
                if (j && !s[0]) begin mst = 1; mvy = V0; end
                else if (!s[1] && my < YF) begin mst = 2; mvy = 0; end
            end
            1: begin
                if (s[0]) begin mst = 2; mvy = 0; end
                else begin
                    my  = (my - mvy < 16) ? 16 : my - mvy;
                    mvy = mvy - 1;
                    if (mvy == 0) mst = 2;
                end
            end
            default: begin
                if (s[1]) mst = 0;
                else if (my + mvy >= YF) begin my = YF; mst = 0; end
                else begin my = my + mvy; mvy = (mvy + 1 > MF) ? MF : mvy + 1; end
            end
        endcase
        moff = (mx <= 160) ? 0 : ((mx - 160 > 3056) ? 3056 : mx - 160);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_x"},   int'(bus.x_mario_center), mx);
        chk({tag, "_y"},   int'(bus.y_mario_center), my);
        chk({tag, "_off"}, int'(bus.offset), moff);
        chk({tag, "_st"},  int'(bus.motion_state_out), mst);
    endtask

    task automatic check_const(input string tag, input int ex, input int ey, input int eoff, input int est);
        chk({tag, "_x"},   int'(bus.x_mario_center), ex);
        chk({tag, "_y"},   int'(bus.y_mario_center), ey);
        chk({tag, "_off"}, int'(bus.offset), eoff);
        chk({tag, "_st"},  int'(bus.motion_state_out), est);
    endtask

    // cb: pulses one cycle before new_frame; cs: with new_frame; cm: two cycles after.
    task automatic run_frame(input bit l, input bit r, input bit j,
                             input bit [3:0] cb, input bit [3:0] cs, input bit [3:0] cm);
        int       ox, oy, ooff, first, ndone;
        bit [3:0] snap;
        if (cb != 4'h0) begin
            drive_coll(cb);
            tick();
            mflags |= cb;
            drive_coll(4'h0);
        end
        bus.new_frame = 1'b1;
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_jump  = j;
        drive_coll(cs);
        tick();
        snap   = mflags;
        mflags = cs;
        bus.new_frame = 1'b0;
        bus.btn_left  = !l;
        bus.btn_right = !r;
        bus.btn_jump  = !j;
        drive_coll(4'h0);
        ox = mx; oy = my; ooff = moff;
        model_frame(l, r, j, snap);
        first = 0;
        ndone = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                drive_coll(cm);
                mflags |= cm;
            end
            if (k == 3) begin
                drive_coll(4'h0);
                chk("hold_x", int'(bus.x_mario_center), ox);
                chk("hold_y", int'(bus.y_mario_center), oy);
                chk("hold_off", int'(bus.offset), ooff);
            end
            if (bus.update_done) begin
                ndone++;
                if (first == 0) begin
                    first = k;
                    check_model("commit");
                end
            end
            tick();
        end
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_jump  = 1'b0;
        chk("latency", first, 4);
        chk("done_pulses", ndone, 1);
    endtask

    task automatic add(input bit l, input bit r, input bit j, input bit [3:0] cb, input bit [3:0] cs,
                       input int ex, input int ey, input int eoff, input int est);
        vec_t v;
        v.l = l; v.r = r; v.j = j; v.cb = cb; v.cs = cs;
        v.ex = ex; v.ey = ey; v.eoff = eoff; v.est = est;
        tbl.push_back(v);
    endtask

    initial begin
        int ndone;
        bus.new_frame = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_jump  = 1'b0;
        drive_coll(4'h0);

        add(0,0,0, CF, 0, 40,207,0,0);
        add(0,0,1, 0,  0, 40,207,0,1);
        add(0,0,0, 0,  0, 40,199,0,1);
        add(0,0,0, 0,  0, 40,192,0,1);
        add(0,0,0, 0,  0, 40,186,0,1);
        add(0,0,0, 0,  0, 40,181,0,1);
        add(0,0,0, 0,  0, 40,177,0,1);
        add(0,0,0, 0,  0, 40,174,0,1);
        add(0,0,0, 0,  0, 40,172,0,1);
        add(0,0,0, 0,  0, 40,171,0,2);
        add(0,0,0, 0,  0, 40,171,0,2);
        add(0,0,0, 0,  0, 40,172,0,2);
        add(0,0,0, 0,  0, 40,174,0,2);
        add(0,0,0, 0,  0, 40,177,0,2);
        add(0,0,0, 0,  0, 40,181,0,2);
        add(0,0,0, 0,  0, 40,186,0,2);
        add(0,0,0, 0,  0, 40,192,0,2);
        add(0,0,0, 0,  0, 40,198,0,2);
        add(0,0,0, 0,  0, 40,204,0,2);
        add(0,0,0, 0,  0, 40,210,0,2);
        add(0,0,0, 0,  0, 40,216,0,2);
        add(0,0,0, 0,  0, 40,222,0,2);
        add(0,0,0, 0,  0, 40,223,0,0);
        add(0,0,1, 0,  0, 40,223,0,1);
        add(0,0,0, 0,  0, 40,215,0,1);
        add(0,0,0, CH, 0, 40,215,0,2);
        add(0,0,0, 0,  0, 40,215,0,2);
        add(0,0,0, 0,  CF,40,216,0,2);
        add(0,0,0, 0,  0, 40,216,0,0);
        add(0,0,0, 0,  0, 40,216,0,2);
        add(0,1,0, 0,  0, 42,216,0,2);
        add(1,1,0, 0,  0, 42,217,0,2);
        add(1,0,0, CL, 0, 42,219,0,2);
        add(1,0,0, 0,  0, 40,222,0,2);
        add(0,0,0, 0,  0, 40,223,0,0);

        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        check_const("reset", XS, YS, 0, 0);
        chk("reset_done", int'(bus.update_done), 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].cb, tbl[i].cs, 4'h0);
            check_const($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].eoff, tbl[i].est);
        end

        for (int i = 0; i < 250; i++) begin
            run_frame(1'($urandom), 1'($urandom), 1'($urandom),
                      4'($urandom) & 4'($urandom),
                      4'($urandom) & 4'($urandom) & 4'($urandom),
                      4'($urandom) & 4'($urandom) & 4'($urandom));
        end

        for (int i = 0; i < 2000 && mx < 3370; i++) run_frame(0,1,0, 0,0,0);
        run_frame(0,1,0, 0,0,0);
        chk("right_wall_x", int'(bus.x_mario_center), 3371);
        chk("right_wall_off", int'(bus.offset), 3056);
        run_frame(0,1,0, 0,0,0);
        chk("right_wall_hold_x", int'(bus.x_mario_center), 3371);

        for (int i = 0; i < 2000 && mx > 159; i++) run_frame(1,0,0, 0,0,0);
        chk("cam_start_x", int'(bus.x_mario_center), 159);
        chk("cam_start_off", int'(bus.offset), 0);
        for (int i = 1; i <= 3; i++) begin
            run_frame(0,1,0, 0,0,0);
            chk("walk_x", int'(bus.x_mario_center), 159 + 2 * i);
            chk("walk_off", int'(bus.offset), 2 * i - 1);
        end
        repeat (2) begin
            run_frame(0,1,0, CR,0,0);
            chk("blocked_x", int'(bus.x_mario_center), 165);
            chk("blocked_off", int'(bus.offset), 5);
        end

        for (int i = 0; i < 200 && mx > 5; i++) run_frame(1,0,0, 0,0,0);
        chk("left_near_x", int'(bus.x_mario_center), 5);
        run_frame(1,0,0, 0,0,0);
        chk("left_wall_x", int'(bus.x_mario_center), 4);
        run_frame(1,0,0, 0,0,0);
        chk("left_wall_hold_x", int'(bus.x_mario_center), 4);

        bus.new_frame = 1'b1;
        bus.btn_right = 1'b1;
        tick();
        bus.new_frame = 1'b0;
        bus.btn_right = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_const("midrst", XS, YS, 0, 0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.update_done) ndone++;
            tick();
        end
        chk("midrst_no_done", ndone, 0);
        check_const("midrst_hold", XS, YS, 0, 0);
        run_frame(0,0,0, CF,0,0);
        check_const("after_rst", XS, YS, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
